// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared types and default sizes for the common data bus (CDB) arbiter.
//   cdb_pkt_t  - one broadcast payload {tag, value, rob_tag}
//   CDB_*      - default FU count, slot count and tag widths
package cdb_arbiter_pkg;

  localparam int CDB_NUM_FU = 4;
  localparam int CDB_SLOTS  = 2;
  localparam int CDB_PHYS_W = 6;
  localparam int CDB_ROB_W  = 6;

  typedef struct packed {
    logic [CDB_PHYS_W-1:0] tag;
    logic [31:0]           value;
    logic [CDB_ROB_W-1:0]  rob_tag;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result handshake from the functional units plus the CDB broadcast bus.
//   fu_valid/fu_ready            - per-FU valid/ready handshake
//   fu_tag/fu_value/fu_rob_tag   - per-FU result payload
//   cdb_valid/tag/value/rob_tag  - per-slot registered broadcast
// Modports: master = arbiter side (accepts results, drives the CDB);
//           slave  = producer/consumer side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int CDB_W  = CDB_SLOTS,
  parameter int PHYS_W = CDB_PHYS_W,
  parameter int ROB_W  = CDB_ROB_W
);
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0]             fu_ready;
  logic [NUM_FU-1:0][PHYS_W-1:0] fu_tag;
  logic [NUM_FU-1:0][31:0]       fu_value;
  logic [NUM_FU-1:0][ROB_W-1:0]  fu_rob_tag;

  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]  cdb_tag;
  logic [CDB_W-1:0][31:0]        cdb_value;
  logic [CDB_W-1:0][ROB_W-1:0]   cdb_rob_tag;

  modport master (
    input  fu_valid, fu_tag, fu_value, fu_rob_tag,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

  modport slave (
    output fu_valid, fu_tag, fu_value, fu_rob_tag,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );
endinterface

// File: rtl/cdb_rr_picker.sv
// cdb_rr_picker: combinational multi-grant round-robin picker.
//   req         in  NUM_FU           requesters
//   rr_ptr      in  IDX_W            first index to scan
//   grant_valid out CDB_W            slot k holds a grant
//   grant_idx   out CDB_W x IDX_W    requester granted to slot k
//   grant_mask  out NUM_FU           one-hot-per-requester view of the grants
//   next_ptr    out IDX_W            last granted index + 1 (wraps), rr_ptr if no grant
// Scan order rr_ptr, rr_ptr+1, ... wrapping; the n-th pending requester found
// goes to slot n, up to CDB_W grants.
module cdb_rr_picker #(
  parameter int NUM_FU = 4,
  parameter int CDB_W  = 2,
  parameter int IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
  input  logic [NUM_FU-1:0]            req,
  input  logic [IDX_W-1:0]             rr_ptr,
  output logic [CDB_W-1:0]             grant_valid,
  output logic [CDB_W-1:0][IDX_W-1:0]  grant_idx,
  output logic [NUM_FU-1:0]            grant_mask,
  output logic [IDX_W-1:0]             next_ptr
);
  localparam logic [IDX_W:0]   NUM_FU_V = (IDX_W+1)'(NUM_FU);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FU - 1);

  always_comb begin
    logic [NUM_FU-1:0] avail;
    logic              found;
    logic [IDX_W:0]    sum;
    logic [IDX_W-1:0]  idx;
    avail       = req;
    found       = 1'b0;
    sum         = '0;
    idx         = '0;
    grant_valid = '0;
    grant_idx   = '0;
    grant_mask  = '0;
    next_ptr    = rr_ptr;
    // Each slot takes the first still-available requester in rotated order;
    // taking it out of avail lets the next slot find the following one.
    for (int k = 0; k < CDB_W; k++) begin
      found = 1'b0;
      for (int j = 0; j < NUM_FU; j++) begin
        sum = {1'b0, rr_ptr} + (IDX_W+1)'(j);
        if (sum >= NUM_FU_V) sum = sum - NUM_FU_V;
        idx = sum[IDX_W-1:0];
        if (!found && avail[idx]) begin
          found           = 1'b1;
          avail[idx]      = 1'b0;
          grant_valid[k]  = 1'b1;
          grant_idx[k]    = idx;
          grant_mask[idx] = 1'b1;
          next_ptr        = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares CDB_W broadcast slots among NUM_FU result producers.
//   clk       in   core clock
//   reset_n   in   asynchronous active-low reset
//   flush_pipeline in  drops every held and outgoing result
//   bus       master modport of cdb_arbiter_if (FU handshake in, CDB out)
//   perf_conflict_cnt out NUM_FU x 16, only with CDB_ARB_PERF_EN defined:
//             saturating count of cycles each FU was held but not granted.
// Each FU owns a one-entry holding register; a granted entry may be refilled
// in the same cycle, so a lone FU streams at one result per cycle.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int CDB_W  = CDB_SLOTS,
  parameter int PHYS_W = CDB_PHYS_W,
  parameter int ROB_W  = CDB_ROB_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush_pipeline,
`ifdef CDB_ARB_PERF_EN
  output logic [NUM_FU-1:0][15:0] perf_conflict_cnt,
`endif
  cdb_arbiter_if.master           bus
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_pkt_t [NUM_FU-1:0]          pend_q, pend_d;
  logic [NUM_FU-1:0]              pend_valid_q, pend_valid_d;
  logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
  logic [CDB_W-1:0]               cdb_valid_q, cdb_valid_d;
  cdb_pkt_t [CDB_W-1:0]           cdb_pkt_q, cdb_pkt_d;

  logic [CDB_W-1:0]               grant_valid;
  logic [CDB_W-1:0][IDX_W-1:0]    grant_idx;
  logic [NUM_FU-1:0]              grant;
  logic [IDX_W-1:0]               next_ptr;
  logic [NUM_FU-1:0]              fu_ready;
  logic [NUM_FU-1:0]              xfer;

  cdb_rr_picker #(
    .NUM_FU (NUM_FU),
    .CDB_W  (CDB_W),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req         (pend_valid_q),
    .rr_ptr      (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_mask  (grant),
    .next_ptr    (next_ptr)
  );

  // Holding stage: accept a new result when empty or leaving this cycle.
  always_comb begin
    fu_ready     = flush_pipeline ? '0 : (~pend_valid_q | grant);
    xfer         = bus.fu_valid & fu_ready;
    pend_valid_d = flush_pipeline ? '0 : ((pend_valid_q & ~grant) | xfer);
    rr_ptr_d     = flush_pipeline ? '0 : next_ptr;
    pend_d       = pend_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (xfer[i]) begin
        pend_d[i].tag     = bus.fu_tag[i];
        pend_d[i].value   = bus.fu_value[i];
        pend_d[i].rob_tag = bus.fu_rob_tag[i];
      end
    end
  end

  // Broadcast stage: granted holding entries move to their CDB slots.
  always_comb begin
    cdb_valid_d = flush_pipeline ? '0 : grant_valid;
    cdb_pkt_d   = '0;
    for (int k = 0; k < CDB_W; k++) begin
      if (cdb_valid_d[k]) cdb_pkt_d[k] = pend_q[grant_idx[k]];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_valid_q <= '0;
      rr_ptr_q     <= '0;
      cdb_valid_q  <= '0;
      cdb_pkt_q    <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      rr_ptr_q     <= rr_ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_pkt_q    <= cdb_pkt_d;
    end
  end

  // Holding payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign bus.fu_ready  = fu_ready;
  assign bus.cdb_valid = cdb_valid_q;
  always_comb begin
    bus.cdb_tag     = '0;
    bus.cdb_value   = '0;
    bus.cdb_rob_tag = '0;
    for (int k = 0; k < CDB_W; k++) begin
      bus.cdb_tag[k]     = cdb_pkt_q[k].tag;
      bus.cdb_value[k]   = cdb_pkt_q[k].value;
      bus.cdb_rob_tag[k] = cdb_pkt_q[k].rob_tag;
    end
  end

`ifdef CDB_ARB_PERF_EN
  logic [NUM_FU-1:0][15:0] perf_cnt_q, perf_cnt_d;

  // Counts held-but-not-granted cycles; survives flush, sticks at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    for (int i = 0; i < NUM_FU; i++) begin
      if (pend_valid_q[i] && !grant[i] && (perf_cnt_q[i] != 16'hFFFF))
        perf_cnt_d[i] = perf_cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_cnt_q <= '0;
    else          perf_cnt_q <= perf_cnt_d;
  end

  assign perf_conflict_cnt = perf_cnt_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (default
// NUM_FU=4, CDB_W=2). Define CDB_ARB_PERF_EN for the conflict-counter case.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush_pipeline = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  cdb_arbiter_if #(.NUM_FU(4), .CDB_W(2), .PHYS_W(6), .ROB_W(6)) bus ();

`ifdef CDB_ARB_PERF_EN
  logic [3:0][15:0] perf_conflict_cnt;
`endif

  cdb_arbiter #(.NUM_FU(4), .CDB_W(2), .PHYS_W(6), .ROB_W(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .flush_pipeline (flush_pipeline),
`ifdef CDB_ARB_PERF_EN
    .perf_conflict_cnt (perf_conflict_cnt),
`endif
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.fu_valid   = '0;
    bus.fu_tag     = '0;
    bus.fu_value   = '0;
    bus.fu_rob_tag = '0;
    flush_pipeline = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    #3;
    n_vec++;
    if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL reset_cdb_valid got %b want 00", bus.cdb_valid); end
    n_vec++;
    if ({bus.cdb_tag, bus.cdb_value, bus.cdb_rob_tag} !== '0) begin n_err++; $display("FAIL reset_cdb_data got %h want 0", {bus.cdb_tag, bus.cdb_value, bus.cdb_rob_tag}); end
    do_reset();
    n_vec++;
    if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL reset_fu_ready got %b want 1111", bus.fu_ready); end
  endtask

  task automatic test_single();
    do_reset();
    bus.fu_valid = 4'b0010;
    bus.fu_tag[1] = 6'd9;
    bus.fu_value[1] = 32'hDEADBEEF;
    bus.fu_rob_tag[1] = 6'd3;
    #1;
    n_vec++;
    if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL single_ready_c0 got %b want 1111", bus.fu_ready); end
    tick();
    bus.fu_valid = '0;
    #1;
    n_vec++;
    if (bus.fu_ready[1] !== 1'b1) begin n_err++; $display("FAIL single_ready_c1 got %b want 1", bus.fu_ready[1]); end
    n_vec++;
    if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL single_valid_c1 got %b want 00", bus.cdb_valid); end
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b01) begin n_err++; $display("FAIL single_valid_c2 got %b want 01", bus.cdb_valid); end
    n_vec++;
    if (bus.cdb_tag[0] !== 6'd9 || bus.cdb_value[0] !== 32'hDEADBEEF || bus.cdb_rob_tag[0] !== 6'd3)
      begin n_err++; $display("FAIL single_slot0 got %0d/%h/%0d want 9/deadbeef/3", bus.cdb_tag[0], bus.cdb_value[0], bus.cdb_rob_tag[0]); end
    n_vec++;
    if (bus.fu_ready[1] !== 1'b1) begin n_err++; $display("FAIL single_ready_c2 got %b want 1", bus.fu_ready[1]); end
  endtask

  task automatic test_all_fire();
    do_reset();
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.fu_tag[i]     = 6'(10 + i);
      bus.fu_value[i]   = 32'hA000_0000 + 32'(i);
      bus.fu_rob_tag[i] = 6'(40 + i);
    end
    tick();
    bus.fu_valid = '0;
    #1;
    n_vec++;
    if (bus.fu_ready !== 4'b0011) begin n_err++; $display("FAIL all_ready_c1 got %b want 0011", bus.fu_ready); end
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_tag[0] !== 6'd10 || bus.cdb_tag[1] !== 6'd11)
      begin n_err++; $display("FAIL all_c2 got v=%b t0=%0d t1=%0d want 11/10/11", bus.cdb_valid, bus.cdb_tag[0], bus.cdb_tag[1]); end
    n_vec++;
    if (bus.cdb_value[1] !== 32'hA000_0001 || bus.cdb_rob_tag[1] !== 6'd41)
      begin n_err++; $display("FAIL all_c2_slot1 got %h/%0d want a0000001/41", bus.cdb_value[1], bus.cdb_rob_tag[1]); end
    n_vec++;
    if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL all_ready_c2 got %b want 1111", bus.fu_ready); end
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_tag[0] !== 6'd12 || bus.cdb_tag[1] !== 6'd13)
      begin n_err++; $display("FAIL all_c3 got v=%b t0=%0d t1=%0d want 11/12/13", bus.cdb_valid, bus.cdb_tag[0], bus.cdb_tag[1]); end
    // Pointer is back at 0: FU0 must win slot 0 over FU3.
    bus.fu_valid = 4'b1001;
    bus.fu_tag[0] = 6'd20;
    bus.fu_tag[3] = 6'd23;
    tick();
    bus.fu_valid = '0;
    #1;
    n_vec++;
    if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL rr_ready got %b want 1111", bus.fu_ready); end
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b11 || bus.cdb_tag[0] !== 6'd20 || bus.cdb_tag[1] !== 6'd23)
      begin n_err++; $display("FAIL rr_wrap got v=%b t0=%0d t1=%0d want 11/20/23", bus.cdb_valid, bus.cdb_tag[0], bus.cdb_tag[1]); end
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL idle_valid got %b want 00", bus.cdb_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      bus.fu_valid   = (c < 6) ? 4'b0001 : 4'b0000;
      bus.fu_tag[0]  = 6'(c);
      bus.fu_value[0] = 32'd100 + 32'(c);
      #1;
      n_vec++;
      if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL b2b_ready c%0d got %b want 1111", c, bus.fu_ready); end
      n_vec++;
      if (c >= 2 && c < 8) begin
        if (bus.cdb_valid !== 2'b01 || bus.cdb_value[0] !== 32'd100 + 32'(c - 2))
          begin n_err++; $display("FAIL b2b_data c%0d got v=%b val=%0d want 01/%0d", c, bus.cdb_valid, bus.cdb_value[0], 100 + c - 2); end
      end else begin
        if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL b2b_idle c%0d got %b want 00", c, bus.cdb_valid); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    bus.fu_valid = 4'b0111;
    bus.fu_tag[0] = 6'd1; bus.fu_tag[1] = 6'd2; bus.fu_tag[2] = 6'd3;
    tick();
    flush_pipeline = 1'b1;
    bus.fu_valid = 4'b1000;
    bus.fu_tag[3] = 6'h3F;
    #1;
    n_vec++;
    if (bus.fu_ready !== 4'b0000) begin n_err++; $display("FAIL flush_ready_during got %b want 0000", bus.fu_ready); end
    tick();
    flush_pipeline = 1'b0;
    bus.fu_valid = '0;
    #1;
    n_vec++;
    if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL flush_cdb got %b want 00", bus.cdb_valid); end
    n_vec++;
    if (bus.fu_ready !== 4'b1111) begin n_err++; $display("FAIL flush_ready_after got %b want 1111", bus.fu_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++;
      if (bus.cdb_valid !== 2'b00) begin n_err++; $display("FAIL flush_drop c%0d got %b want 00", c, bus.cdb_valid); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.fu_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus.fu_tag[i] = 6'(30 + i);
    tick();
    bus.fu_valid = '0;
    tick();
    n_vec++;
    if (bus.cdb_valid !== 2'b11) begin n_err++; $display("FAIL areset_pre got %b want 11", bus.cdb_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (bus.cdb_valid !== 2'b00 || bus.cdb_tag !== '0) begin n_err++; $display("FAIL areset_now got v=%b t=%h want 00/0", bus.cdb_valid, bus.cdb_tag); end
    #2;
    reset_n = 1'b1;
    tick();
    n_vec++;
    if (bus.fu_ready !== 4'b1111 || bus.cdb_valid !== 2'b00)
      begin n_err++; $display("FAIL areset_after got r=%b v=%b want 1111/00", bus.fu_ready, bus.cdb_valid); end
  endtask

`ifdef CDB_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    // All four stream for 9 cycles: FU2/FU3 lose on odd cycles 1..9, FU0/FU1 on 2..8.
    bus.fu_valid = 4'b1111;
    repeat (9) tick();
    bus.fu_valid = '0;
    repeat (4) tick();
    n_vec++;
    if (perf_conflict_cnt[3] !== 16'd5) begin n_err++; $display("FAIL perf_fu3 got %0d want 5", perf_conflict_cnt[3]); end
    n_vec++;
    if (perf_conflict_cnt[0] !== 16'd4) begin n_err++; $display("FAIL perf_fu0 got %0d want 4", perf_conflict_cnt[0]); end
    force dut.perf_cnt_q = {4{16'hFFFF}};
    #1;
    release dut.perf_cnt_q;
    bus.fu_valid = 4'b1111;
    repeat (4) tick();
    bus.fu_valid = '0;
    repeat (3) tick();
    n_vec++;
    if (perf_conflict_cnt[3] !== 16'hFFFF) begin n_err++; $display("FAIL perf_sat got %h want ffff", perf_conflict_cnt[3]); end
  endtask
`endif

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_all_fire();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef CDB_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
